// File: rtl/regfile_scan_checker.sv
// Runs the processor for a set number of cycles while counting writebacks, then takes over
// regfile read port A and compares every register against an expected-value ROM.
module regfile_scan_checker #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int CYCLE_WIDTH = 16,
  parameter int WB_WIDTH    = 16,
  parameter int CHECK_R0    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CYCLE_WIDTH-1:0]  num_cycles,
  input  logic                    rwe,
  input  logic [ADDR_WIDTH-1:0]   rd,
  input  logic [ADDR_WIDTH-1:0]   rs1_cpu,
  output logic [ADDR_WIDTH-1:0]   rs1_out,
  input  logic [DATA_WIDTH-1:0]   regA,
  output logic [ADDR_WIDTH-1:0]   exp_addr,
  input  logic [DATA_WIDTH-1:0]   exp_data,
  output logic                    test_mode,
  output logic [WB_WIDTH-1:0]     wb_count,
  output logic [ADDR_WIDTH:0]     error_count,
  output logic                    done,
  output logic                    pass,
  output logic                    first_fail_valid,
  output logic [ADDR_WIDTH-1:0]   first_fail_reg,
  output logic [DATA_WIDTH-1:0]   first_fail_exp,
  output logic [DATA_WIDTH-1:0]   first_fail_act
);

  typedef enum logic [2:0] {IDLE, RUN, SCAN, DRAIN, DONE} state_t;

  localparam logic [CYCLE_WIDTH-1:0] CNT_ONE = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WB_WIDTH-1:0]    WB_ONE  = {{(WB_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0]  IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]    ERR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                 state;
  logic [CYCLE_WIDTH-1:0] cnt;
  logic [CYCLE_WIDTH-1:0] last_cnt;
  logic [ADDR_WIDTH-1:0]  scan_idx;
  logic [ADDR_WIDTH-1:0]  cap_idx;
  logic [DATA_WIDTH-1:0]  cap_val;
  logic                   cap_vld;
  logic                   mismatch;

  assign rs1_out  = test_mode ? scan_idx : rs1_cpu;
  assign exp_addr = scan_idx;
  assign pass     = done && (error_count == '0);

  // exp_data arrives one cycle after exp_addr, lining up with the captured regA
  assign mismatch = cap_vld && (cap_val != exp_data) && ((CHECK_R0 != 0) || (cap_idx != '0));

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      cnt              <= '0;
      last_cnt         <= '0;
      scan_idx         <= '0;
      cap_idx          <= '0;
      cap_val          <= '0;
      cap_vld          <= 1'b0;
      test_mode        <= 1'b0;
      wb_count         <= '0;
      error_count      <= '0;
      done             <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_reg   <= '0;
      first_fail_exp   <= '0;
      first_fail_act   <= '0;
    end else begin
      cap_vld <= 1'b0;

      if (mismatch) begin
        error_count <= error_count + ERR_ONE;
        if (!first_fail_valid) begin
          first_fail_valid <= 1'b1;
          first_fail_reg   <= cap_idx;
          first_fail_exp   <= exp_data;
          first_fail_act   <= cap_val;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= RUN;
            cnt              <= '0;
            // zero cycles is treated as a single RUN cycle
            last_cnt         <= (num_cycles == '0) ? '0 : num_cycles - CNT_ONE;
            wb_count         <= '0;
            error_count      <= '0;
            done             <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_reg   <= '0;
            first_fail_exp   <= '0;
            first_fail_act   <= '0;
          end
        end
        RUN: begin
          if (rwe && (rd != '0) && (wb_count != '1))
            wb_count <= wb_count + WB_ONE;
          if (cnt == last_cnt) begin
            state     <= SCAN;
            test_mode <= 1'b1;
            scan_idx  <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        SCAN: begin
          cap_val  <= regA;
          cap_idx  <= scan_idx;
          cap_vld  <= 1'b1;
          scan_idx <= scan_idx + IDX_ONE;
          if (scan_idx == '1)
            state <= DRAIN;
        end
        DRAIN: begin
          state     <= DONE;
          test_mode <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_scan_checker.md
Name: regfile_scan_checker

Overview:
- Synthesizable, parametrised successor to the simulation-only register-check harness.
- Runs the processor for a programmed number of cycles and counts nonzero-destination writebacks.
- Then takes over the regfile A read port, scans every register and compares each value against an expected-value ROM.
- Reports pass/fail, error count and the first mismatch; sits between processor rs1 and regfile ctrl_readRegA.

Parameters:
- DATA_WIDTH, 32, register/expected data width
- ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
- CYCLE_WIDTH, 16, width of run-length counter
- WB_WIDTH, 16, width of writeback counter (saturating)
- CHECK_R0, 1, 0 = register 0 always counted as pass

Ports:
- clock  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a run; honoured in IDLE or DONE only
- num_cycles  in  CYCLE_WIDTH  run length, sampled on accepted start
- rwe  in  1  processor ctrl_writeEnable (monitor)
- rd  in  ADDR_WIDTH  processor ctrl_writeReg (monitor)
- rs1_cpu  in  ADDR_WIDTH  processor ctrl_readRegA
- rs1_out  out  ADDR_WIDTH  to regfile ctrl_readRegA
- regA  in  DATA_WIDTH  regfile data_readRegA, combinational w.r.t. rs1_out
- exp_addr  out  ADDR_WIDTH  expected-ROM address
- exp_data  in  DATA_WIDTH  expected-ROM data, valid 1 cycle after exp_addr
- test_mode  out  1  high while the harness owns the read port
- wb_count  out  WB_WIDTH  writebacks with rd!=0 during RUN
- error_count  out  ADDR_WIDTH+1  mismatches found
- done  out  1  high in DONE
- pass  out  1  done && error_count==0
- first_fail_valid  out  1  a mismatch has been captured
- first_fail_reg  out  ADDR_WIDTH  index of first mismatch
- first_fail_exp  out  DATA_WIDTH  expected value at first mismatch
- first_fail_act  out  DATA_WIDTH  actual value at first mismatch

Behaviour:
- Reset:
  - state=IDLE; all counters, first_fail_* and done/pass/test_mode are 0.
  - rs1_out follows rs1_cpu and exp_addr=0.
  - Reset in any state aborts immediately to this condition.
- rs1_out = test_mode ? scan_idx : rs1_cpu (combinational mux). exp_addr = scan_idx.
- States:
  - IDLE: wait for start.
  - RUN: cycle counter cnt counts up from 0. Each cycle with rwe && rd!=0 increments wb_count, saturating at all-ones. When cnt == num_cycles-1, go to SCAN. num_cycles==0 behaves like 1, so RUN lasts exactly one cycle.
  - SCAN: test_mode=1. scan_idx steps 0..NUM_REGS-1, one per cycle. Each cycle, regA is registered along with the index (stage-1 pipeline). After the last index, go to DRAIN.
  - DRAIN: test_mode=1, one cycle; completes the final comparison.
  - DONE: test_mode=0, done=1; all results held stable until start or reset.
- Start handling:
  - Accepted start clears wb_count, error_count, first_fail_* and done, then enters RUN.
  - start in RUN, SCAN or DRAIN is ignored.
- Compare pipeline:
  - In cycle k, idx i is presented on both rs1_out and exp_addr, and regA is captured.
  - In cycle k+1, the captured value is compared with exp_data using a full DATA_WIDTH exact compare.
  - A mismatch increments error_count. Reg 0 never mismatches when CHECK_R0=0.
  - The first mismatch latches reg/exp/act and sets first_fail_valid. Later mismatches do not overwrite it.
- Latency: start to done = max(num_cycles,1) + NUM_REGS + 1 (DRAIN) + 1 cycles.
- The processor is not stalled. Its writebacks during SCAN are not counted, and they are visible in the scan only if committed before the index is read.
- error_count max is NUM_REGS, so the ADDR_WIDTH+1 width cannot overflow.

Test Plan:
- Reset, then start with num_cycles=10; rwe=1 with rd=3 on 4 cycles and rd=0 on 2 cycles → wb_count=4. done rises exactly 10+32+2=44 cycles after start.
- All expected values equal the regfile contents → error_count=0, pass=1, first_fail_valid=0. test_mode is high for exactly 33 cycles.
- Regs 7 and 20 mismatch (exp 5 vs act 6; exp -1 vs act 0) → error_count=2, first_fail_reg=7, first_fail_exp=5, first_fail_act=6.
- CHECK_R0=0 with reg 0 mismatching → error_count=0. With CHECK_R0=1 → error_count=1, first_fail_reg=0.
- num_cycles=0 → RUN lasts 1 cycle. A start pulse mid-SCAN is ignored (counters unchanged). A start in DONE clears results and reruns.
- Assert reset during SCAN at idx 12 → next cycle state=IDLE, test_mode=0, rs1_out=rs1_cpu, error_count=0.
